gf2m_digit_mult: RTL

- Parametrised digit-serial GF(2^M) multiplier, MSB-first, with interleaved polynomial reduction.
- Computes C = A·B mod f(x), where f(x) = x^M + POLY.
- Each clock consumes D bits of B through a combinational chain of D bit-slice steps. Each step is c_i' = c_{i-1} ^ (c_{M-1} & g_i) ^ (a_i & b_bit).
- Sits under the ECC point-arithmetic controller. Replaces the fixed-width 163-bit cell array with a start/done sequenced core.

---
 rtl/gf2m_digit_mult.sv | 111 +++++++++++
 1 files changed

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) multiplier, MSB-first, with interleaved reduction.
// Computes c_out = a_in * b_in mod (x^M + POLY), consuming D bits of B per
// clock over N = ceil(M/D) RUN cycles, sequenced by a start/done handshake.
module gf2m_digit_mult #(
  parameter int          M    = 163,
  parameter int          D    = 8,
  parameter logic [M-1:0] POLY = M'(163'h00000000000000000000000000000000000000C9)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a_in,
  input  logic [M-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c_out
);

  // Number of digit cycles, padded multiplier width and counter width.
  localparam int N  = (M + D - 1) / D;
  localparam int NB = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e         state_q, state_d;
  logic [M-1:0]   aOp_q, aOp_d;
  logic [NB-1:0]  bOp_q, bOp_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   cOut_q, cOut_d;
  logic           done_q, done_d;
  logic [M-1:0]   accNext;

  // The multiplier register is shifted left each digit so the current digit
  // always sits in its top D bits; this walks B MSB-first without a mux on
  // the counter.
  // Combinational chain of D bit-slice steps applied to the accumulator.
  always_comb begin
    accNext = acc_q;
    for (int i = 0; i < D; i++) begin
      accNext = (accNext << 1)
              ^ (accNext[M-1] ? POLY : '0)
              ^ (bOp_q[NB-1-i] ? aOp_q : '0);
    end
  end

  // Next-state and datapath update for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cOut_d  = cOut_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          aOp_d   = a_in;
          bOp_d   = NB'(b_in);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = accNext;
        bOp_d = bOp_q << D;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cOut_d  = accNext;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aOp_q   <= '0;
      bOp_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cOut_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cOut_q  <= cOut_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign c_out = cOut_q;

endmodule
